// File: rtl/dram_init_arbiter_pkg.sv
// Shared DDR3 definitions for the DRAM-facing blocks: native interface widths,
// arbiter state encoding and the one-hot channel grant.
package dram_init_arbiter_pkg;

  localparam int DDR3AddrWidth = 27;
  localparam int DDR3CmdWidth  = 3;
  localparam int DDR3DataWidth = 512;

  typedef enum logic [1:0] {
    WaitPHY = 2'd0,
    Init    = 2'd1,
    Settle  = 2'd2,
    Run     = 2'd3
  } arbState_e;

  // Bit 0 selects the initializer side, bit 1 the ORAM backend side.
  typedef enum logic [1:0] {
    GrantNone = 2'b00,
    GrantInit = 2'b01,
    GrantOram = 2'b10
  } grant_e;

endpackage

// File: rtl/dram_channel_mux.sv
// 2:1 valid/ready/payload multiplexer steered by a one-hot grant. Sources that
// are not granted see Ready low and never reach the sink.
module dram_channel_mux
  import dram_init_arbiter_pkg::*;
#(
  parameter int Width = 1
) (
  input  grant_e           grant,
  input  logic             initValid,
  input  logic [Width-1:0] initPayload,
  output logic             initReady,
  input  logic             oramValid,
  input  logic [Width-1:0] oramPayload,
  output logic             oramReady,
  output logic             outValid,
  output logic [Width-1:0] outPayload,
  input  logic             outReady
);

  assign initReady  = grant[0] & outReady;
  assign oramReady  = grant[1] & outReady;
  assign outValid   = (grant[0] & initValid) | (grant[1] & oramValid);
  // Payload is don't-care while nothing is granted.
  assign outPayload = grant[1] ? oramPayload : initPayload;

endmodule

// File: rtl/dram_init_arbiter.sv
// Gives the DDR3 native interface to the bucket initializer until it finishes,
// waits a settle window, then hands it permanently to the ORAM backend.
module dram_init_arbiter
  import dram_init_arbiter_pkg::*;
#(
  parameter int DDRAWidth    = DDR3AddrWidth,
  parameter int DDRCWidth    = DDR3CmdWidth,
  parameter int DDRDWidth    = DDR3DataWidth,
  parameter int SettleCycles = 16,
  parameter int CntWidth     = 32
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 PHYInitDone,
  input  logic [DDRAWidth-1:0] InitCmdAddress,
  input  logic [DDRCWidth-1:0] InitCmd,
  input  logic                 InitCmdValid,
  output logic                 InitCmdReady,
  input  logic [DDRDWidth-1:0] InitWData,
  input  logic                 InitWDataValid,
  output logic                 InitWDataReady,
  input  logic                 InitDone,
  input  logic [DDRAWidth-1:0] ORAMCmdAddress,
  input  logic [DDRCWidth-1:0] ORAMCmd,
  input  logic                 ORAMCmdValid,
  output logic                 ORAMCmdReady,
  input  logic [DDRDWidth-1:0] ORAMWData,
  input  logic                 ORAMWDataValid,
  output logic                 ORAMWDataReady,
  output logic [DDRAWidth-1:0] DRAMCommandAddress,
  output logic [DDRCWidth-1:0] DRAMCommand,
  output logic                 DRAMCommandValid,
  input  logic                 DRAMCommandReady,
  output logic [DDRDWidth-1:0] DRAMWriteData,
  output logic                 DRAMWriteDataValid,
  input  logic                 DRAMWriteDataReady,
  output logic                 Ready,
  output logic                 InitError
);

  if (SettleCycles < 1) begin : gBadSettle
    $error("dram_init_arbiter: SettleCycles must be at least 1");
  end

  localparam int SettleWidth = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam int CmdPayloadWidth = DDRAWidth + DDRCWidth;
  localparam logic [SettleWidth-1:0] SettleLast = SettleWidth'(SettleCycles - 1);

  arbState_e state, stateNext;
  grant_e    grant;

  logic [SettleWidth-1:0] settleCnt;
  logic [CntWidth-1:0]    cmdTally, cmdTallyNext;
  logic [CntWidth-1:0]    beatTally, beatTallyNext;
  logic                   cmdFire, beatFire;

  // NOTE: reset is synchronous, so Reset is sampled at the edge and is absent
  // from the sensitivity list; state uses non-blocking assignments only.
  always_ff @(posedge Clock) begin
    if (!Reset) state <= WaitPHY;
    else        state <= stateNext;
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    stateNext = state;
    unique case (state)
      WaitPHY: if (PHYInitDone)             stateNext = Init;
      Init:    if (InitDone)                stateNext = Settle;
      Settle:  if (settleCnt == SettleLast) stateNext = Run;
      Run:                                  stateNext = Run;
      default:                              stateNext = WaitPHY;
    endcase
  end

  always_comb begin
    grant = GrantNone;
    Ready = 1'b0;
    unique case (state)
      Init:    grant = GrantInit;
      Run: begin
        grant = GrantOram;
        Ready = 1'b1;
      end
      default: grant = GrantNone;
    endcase
  end

  dram_channel_mux #(.Width(CmdPayloadWidth)) uCmdMux (
    .grant      (grant),
    .initValid  (InitCmdValid),
    .initPayload({InitCmdAddress, InitCmd}),
    .initReady  (InitCmdReady),
    .oramValid  (ORAMCmdValid),
    .oramPayload({ORAMCmdAddress, ORAMCmd}),
    .oramReady  (ORAMCmdReady),
    .outValid   (DRAMCommandValid),
    .outPayload ({DRAMCommandAddress, DRAMCommand}),
    .outReady   (DRAMCommandReady)
  );

  dram_channel_mux #(.Width(DDRDWidth)) uDataMux (
    .grant      (grant),
    .initValid  (InitWDataValid),
    .initPayload(InitWData),
    .initReady  (InitWDataReady),
    .oramValid  (ORAMWDataValid),
    .oramPayload(ORAMWData),
    .oramReady  (ORAMWDataReady),
    .outValid   (DRAMWriteDataValid),
    .outPayload (DRAMWriteData),
    .outReady   (DRAMWriteDataReady)
  );

  // Initializer readies are only high in Init, so these are Init handshakes.
  assign cmdFire  = InitCmdValid & InitCmdReady;
  assign beatFire = InitWDataValid & InitWDataReady;

  // Saturating tallies; the next values feed the InitDone comparison so a
  // handshake in the same cycle as InitDone is included.
  always_comb begin
    cmdTallyNext  = cmdTally;
    beatTallyNext = beatTally;
    if (cmdFire && (cmdTally != '1))   cmdTallyNext  = cmdTally + CntWidth'(1);
    if (beatFire && (beatTally != '1)) beatTallyNext = beatTally + CntWidth'(1);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cmdTally  <= '0;
      beatTally <= '0;
      settleCnt <= '0;
      InitError <= 1'b0;
    end else begin
      cmdTally  <= cmdTallyNext;
      beatTally <= beatTallyNext;
      if (state == Settle) settleCnt <= settleCnt + SettleWidth'(1);
      else                 settleCnt <= '0;
      if ((state == Init) && InitDone && (cmdTallyNext != beatTallyNext))
        InitError <= 1'b1;
    end
  end

endmodule
